// File: rtl/pc_sequencer.sv
// pc_sequencer: sequences the PC datapath controls for FETCH/LOAD/LOAD_INC/PUSH commands from decode.
// Ports: phi_2 clock (state updates on its falling edge), res_n async active-low reset, rdy freeze-when-low,
//   cmd_valid/cmd/cmd_len/cmd_ready command handshake, done/cmd_err completion status,
//   pcl_pcl/pch_pch/adl_pcl/adh_pch/i_pc PC register controls, pcl_adl/pch_adh/pcl_db/pch_db bus drives.
module pc_sequencer (
  input  logic       phi_2,
  input  logic       res_n,
  input  logic       rdy,
  input  logic       cmd_valid,
  input  logic [2:0] cmd,
  input  logic [1:0] cmd_len,
  output logic       cmd_ready,
  output logic       done,
  output logic       cmd_err,
  output logic       pcl_pcl,
  output logic       pch_pch,
  output logic       adl_pcl,
  output logic       adh_pch,
  output logic       i_pc,
  output logic       pcl_adl,
  output logic       pch_adh,
  output logic       pcl_db,
  output logic       pch_db
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, LOADINC, PUSH_H, PUSH_L} state_t;
  state_t state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic pend_done, pend_err, pend_done_nx, pend_err_nx;
  logic last, load, accept;
  always_ff @(negedge phi_2 or negedge res_n)
    if (!res_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      pend_done <= 1'b0;
      pend_err  <= 1'b0;
    end else if (rdy) begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend_done <= pend_done_nx;
      pend_err  <= pend_err_nx;
    end
  // NOP/illegal completion is tracked by pend_done/pend_err while the state stays IDLE.
  always_comb begin
    last      = pend_done | (state == FETCH && cnt == 2'd0) | state == LOAD | state == LOADINC | state == PUSH_L;
    done      = rdy & last;
    cmd_ready = rdy & (state == IDLE | last);
    cmd_err   = rdy & pend_err;
    load      = rdy & (state == LOAD | state == LOADINC);
    adl_pcl   = load;
    adh_pch   = load;
    pcl_pcl   = ~load;
    pch_pch   = ~load;
    i_pc      = rdy & (state == FETCH | state == LOADINC);
    pcl_adl   = state == FETCH;
    pch_adh   = state == FETCH;
    pch_db    = state == PUSH_H;
    pcl_db    = state == PUSH_L;
    accept    = cmd_valid & cmd_ready;
    cnt_nx       = (state == FETCH && cnt != 2'd0) ? cnt - 2'd1 : cnt;
    pend_done_nx = 1'b0;
    pend_err_nx  = 1'b0;
    state_nx     = (state == IDLE | last) ? IDLE : state == PUSH_H ? PUSH_L : state;
    if (accept)
      case (cmd)
        3'd0: pend_done_nx = 1'b1;
        3'd1: begin
          state_nx = FETCH;
          cnt_nx   = cmd_len;
        end
        3'd2: state_nx = LOAD;
        3'd3: state_nx = LOADINC;
        3'd4: state_nx = PUSH_H;
        default: begin
          pend_done_nx = 1'b1;
          pend_err_nx  = 1'b1;
        end
      endcase
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: checks pc_sequencer against a per-cycle operation queue model and a PC datapath model.
module tb_pc_sequencer;
  logic phi_2 = 1'b0;
  logic res_n, rdy, cmd_valid;
  logic [2:0] cmd;
  logic [1:0] cmd_len;
  logic cmd_ready, done, cmd_err, pcl_pcl, pch_pch, adl_pcl, adh_pch, i_pc, pcl_adl, pch_adh, pcl_db, pch_db;
  logic [11:0] outs;
  logic [15:0] pc, addr_seen;
  logic [7:0] adl, adh;
  int checks = 0, failures = 0;
  int q[$];
  localparam int K_IDLE = 0, K_FETCH = 1, K_FLAST = 2, K_LOAD = 3, K_LINC = 4, K_PH = 5, K_PL = 6, K_NOP = 7, K_ERR = 8;
  pc_sequencer dut (
    .phi_2(phi_2), .res_n(res_n), .rdy(rdy), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .done(done), .cmd_err(cmd_err), .pcl_pcl(pcl_pcl), .pch_pch(pch_pch),
    .adl_pcl(adl_pcl), .adh_pch(adh_pch), .i_pc(i_pc), .pcl_adl(pcl_adl), .pch_adh(pch_adh),
    .pcl_db(pcl_db), .pch_db(pch_db)
  );
  assign outs = {cmd_ready, done, cmd_err, pcl_pcl, pch_pch, adl_pcl, adh_pch, i_pc, pcl_adl, pch_adh, pcl_db, pch_db};
  always #5 phi_2 = ~phi_2;
  function automatic logic [11:0] exp_out(input int k, input logic r);
    logic last, ld;
    last = k inside {K_FLAST, K_LOAD, K_LINC, K_PL, K_NOP, K_ERR};
    ld   = r & (k == K_LOAD || k == K_LINC);
    return {r & (k == K_IDLE || last), r & last, r & (k == K_ERR), ~ld, ~ld, ld, ld,
            r & (k inside {K_FETCH, K_FLAST, K_LINC}), k inside {K_FETCH, K_FLAST}, k inside {K_FETCH, K_FLAST},
            k == K_PL, k == K_PH};
  endfunction
  task automatic push_cmd(input logic [2:0] c, input logic [1:0] l);
    case (c)
      3'd0: q.push_back(K_NOP);
      3'd1: begin
        for (int i = 0; i < int'(l); i++) q.push_back(K_FETCH);
        q.push_back(K_FLAST);
      end
      3'd2: q.push_back(K_LOAD);
      3'd3: q.push_back(K_LINC);
      3'd4: begin
        q.push_back(K_PH);
        q.push_back(K_PL);
      end
      default: q.push_back(K_ERR);
    endcase
  endtask
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input string tag);
    logic [11:0] e, ctl;
    logic acc;
    @(posedge phi_2);
    e = exp_out(q.size() != 0 ? q[0] : K_IDLE, rdy);
    chk(tag, {4'b0, outs}, {4'b0, e});
    acc = cmd_valid & e[11];
    ctl = outs;
    addr_seen = pc;
    @(negedge phi_2);
    if (ctl[6]) pc[7:0] = adl;
    if (ctl[5]) pc[15:8] = adh;
    if (ctl[4]) pc = pc + 16'd1;
    if (rdy) begin
      if (q.size() != 0) void'(q.pop_front());
      if (acc) push_cmd(cmd, cmd_len);
    end
    #1;
  endtask
  task automatic issue(input logic [2:0] c, input logic [1:0] l, input string tag);
    cmd = c;
    cmd_len = l;
    cmd_valid = 1'b1;
    tick(tag);
    cmd_valid = 1'b0;
  endtask
  initial begin
    res_n = 1'b0;
    rdy = 1'b1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    cmd_len = 2'd0;
    adl = 8'h00;
    adh = 8'h00;
    pc = 16'h0000;
    #3 chk("reset_outs", {4'b0, outs}, {4'b0, exp_out(K_IDLE, 1'b1)});
    #9 res_n = 1'b1;
    tick("idle");
    pc = 16'h12FE;
    issue(3'd1, 2'd3, "fetch_acc");
    for (int i = 0; i < 4; i++) begin
      tick("fetch_cyc");
      chk("fetch_addr", addr_seen, 16'h12FE + 16'(i));
    end
    chk("fetch_pc_end", pc, 16'h1302);
    tick("fetch_idle");
    adl = 8'h34;
    adh = 8'hC0;
    issue(3'd3, 2'd0, "ldinc_acc");
    cmd = 3'd1;
    cmd_len = 2'd1;
    cmd_valid = 1'b1;
    tick("ldinc_b2b");
    cmd_valid = 1'b0;
    chk("ldinc_pc", pc, 16'hC035);
    tick("b2b_fetch1");
    chk("b2b_addr1", addr_seen, 16'hC035);
    tick("b2b_fetch2");
    chk("b2b_addr2", addr_seen, 16'hC036);
    chk("b2b_pc_end", pc, 16'hC037);
    issue(3'd2, 2'd0, "load_acc");
    tick("load_cyc");
    chk("load_pc", pc, 16'hC034);
    pc = 16'hABCD;
    issue(3'd4, 2'd0, "push_acc");
    rdy = 1'b0;
    repeat (3) tick("push_stall");
    rdy = 1'b1;
    tick("push_h");
    tick("push_l");
    chk("push_pc", pc, 16'hABCD);
    tick("push_idle");
    issue(3'd6, 2'd0, "ill_acc");
    tick("ill_pulse");
    tick("ill_idle");
    chk("ill_pc", pc, 16'hABCD);
    issue(3'd0, 2'd0, "nop_acc");
    tick("nop_pulse");
    tick("nop_idle");
    issue(3'd7, 2'd0, "ill_stall_acc");
    rdy = 1'b0;
    repeat (2) tick("ill_stall");
    rdy = 1'b1;
    tick("ill_stall_pulse");
    tick("ill_stall_idle");
    pc = 16'hFFFF;
    issue(3'd1, 2'd1, "wrap_acc");
    tick("wrap_c1");
    chk("wrap_addr1", addr_seen, 16'hFFFF);
    chk("wrap_pc1", pc, 16'h0000);
    tick("wrap_c2");
    chk("wrap_addr2", addr_seen, 16'h0000);
    chk("wrap_pc2", pc, 16'h0001);
    issue(3'd1, 2'd3, "rst_acc");
    tick("rst_c1");
    #2 res_n = 1'b0;
    #1 q.delete();
    chk("rst_mid_outs", {4'b0, outs}, {4'b0, exp_out(K_IDLE, 1'b1)});
    @(posedge phi_2);
    #2 res_n = 1'b1;
    tick("rst_after1");
    tick("rst_after2");
    for (int n = 0; n < 400; n++) begin
      rdy = $urandom_range(0, 3) != 0;
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd = 3'($urandom_range(0, 7));
      cmd_len = 2'($urandom_range(0, 3));
      adl = 8'($urandom);
      adh = 8'($urandom);
      tick("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that sequences the program counter datapath (PCL/PCH select, incrementer and registers) under command from instruction decode. It accepts one PC operation at a time over a valid/ready handshake: fetch-with-increment bursts, absolute load, load-and-increment, and a two-cycle PC push onto the data bus. It drives every PC control line and reports completion. It sits between decode and the PC low/high register pair.

## Interface
- No parameters.
- `phi_2` input, 1 bit: system clock. All state updates on the falling edge of `phi_2`, the same edge the PC registers load on.
- `res_n` input, 1 bit: asynchronous active-low reset.
- `rdy` input, 1 bit: CPU ready. Low freezes the sequencer.
- `cmd_valid` input, 1 bit: command offered.
- `cmd` input, 3 bits: 000 NOP, 001 FETCH, 010 LOAD, 011 LOAD_INC, 100 PUSH. 101–111 are illegal.
- `cmd_len` input, 2 bits: FETCH byte count minus 1, giving 1–4 bytes. Ignored for other commands.
- `cmd_ready` output, 1 bit: command is accepted on an edge where `cmd_valid & cmd_ready`.
- `done` output, 1 bit: high during the final cycle of an operation.
- `cmd_err` output, 1 bit: one-cycle pulse after an illegal command is accepted.
- `pcl_pcl`, `pch_pch` outputs, 1 bit each: recirculate PCL/PCH.
- `adl_pcl`, `adh_pch` outputs, 1 bit each: load PCL/PCH from the ADL/ADH buses.
- `i_pc` output, 1 bit: increment PC.
- `pcl_adl`, `pch_adh` outputs, 1 bit each: drive the PC onto the address buses.
- `pcl_db`, `pch_db` outputs, 1 bit each: drive PCL/PCH onto the data bus.

## Operation
- States: IDLE, FETCH, LOAD, LOADINC, PUSH_H, PUSH_L. There is a 2-bit down-counter `cnt`.
- Idle control values: `pcl_pcl=pch_pch=1`, all other control outputs 0.
- In every cycle, exactly one of `pcl_pcl`/`adl_pcl` is 1, and exactly one of `pch_pch`/`adh_pch` is 1.
- IDLE: `cmd_ready=1`. On accept, the next state follows from `cmd`:
  - FETCH → FETCH, with `cnt=cmd_len`.
  - LOAD → LOAD.
  - LOAD_INC → LOADINC.
  - PUSH → PUSH_H.
  - NOP → stay IDLE and pulse `done` the next cycle.
  - Illegal → stay IDLE and pulse `cmd_err` and `done` the next cycle.
- FETCH: `pcl_adl=pch_adh=1`, `i_pc=1`, recirculate.
  - If `cnt≠0`, decrement `cnt`.
  - If `cnt=0`, assert `done`.
- LOAD: `adl_pcl=adh_pch=1`, `i_pc=0`, `done=1`. Lasts one cycle.
- LOADINC: `adl_pcl=adh_pch=1`, `i_pc=1`, `done=1`. The loaded value is incremented in the same cycle.
- PUSH_H: `pch_db=1`, recirculate. Next state is PUSH_L.
- PUSH_L: `pcl_db=1`, recirculate, `done=1`.
- Back-to-back commands:
  - `cmd_ready = (state==IDLE) | done`. A command accepted in the last cycle starts on the next cycle with no bubble.
  - If nothing is accepted in the last cycle, the next state is IDLE.
- PCH carry comes from the incrementer chain. The sequencer never handles carry or wrap-around, so FETCH at $FFFF wraps to $0000 without sequencer involvement.

## Timing
- Reset (`res_n=0`, asynchronous) sets:
  - state IDLE, `cnt=0`;
  - `cmd_ready=1`, `done=0`, `cmd_err=0`;
  - idle control values.
- Reset mid-operation aborts it immediately. No `done` is produced for the aborted command.
- Control outputs are decoded from registered state and `rdy` only, with no combinational path from `cmd_valid`/`cmd`. An operation's first-cycle controls appear after the accepting edge, and the PC loads on the following edge.
- Latency from accept to `done`: FETCH takes `cmd_len+1` cycles, LOAD and LOADINC take 1, PUSH takes 2. NOP and illegal commands take 1 (the `done` pulse).
- When `rdy=0`:
  - state and `cnt` hold;
  - `cmd_ready=0`, `done=0`;
  - `i_pc=0`, `adl_pcl=adh_pch=0`, `pcl_pcl=pch_pch=1`;
  - bus drives (`pcl_adl`, `pch_adh`, `pcl_db`, `pch_db`) keep their state-decoded values;
  - operation resumes on the cycle `rdy` returns high.
- A `cmd_err` pulse already pending when `rdy` falls is held until `rdy` returns.

## Test plan
- Reset:
  - Pulse `res_n` low between edges → outputs take reset values immediately.
  - Assert reset during FETCH len 4, cycle 2 → IDLE, no `done`, and `i_pc=0` at once.
- FETCH burst: PC=$12FE, FETCH `cmd_len=3` →
  - 4 cycles of `i_pc=1`, `pcl_adl=pch_adh=1`;
  - PC visits $12FE, $12FF, $1300, $1301 and ends at $1302;
  - `done` is high only in cycle 4.
- Back-to-back: LOAD_INC with ADL=$34, ADH=$C0, then FETCH len 1 accepted while `done=1` →
  - PC is $C035 after the load;
  - no idle cycle between the operations;
  - address bus shows $C035.
- PUSH then rdy stall: PC=$ABCD, PUSH, with `rdy` low for 3 cycles during PUSH_H →
  - `pch_db=1` stays high for 4 cycles, then `pcl_db=1` for 1 cycle with `done`;
  - PC remains $ABCD.
- Illegal and NOP commands:
  - `cmd=110` → `cmd_err` and `done` pulse 1 cycle later, no control change.
  - NOP → `done` pulse only.
- Wrap: PC=$FFFF, FETCH len 1 → PC becomes $0000, and the sequencer behaves identically to the non-wrap case.
